// File: rtl/cosmem_pkg.sv
// Shared types and bus-cycle constants for the COSMAC 1802 memory controller.
package cosmem_pkg;

    typedef enum logic [1:0] {
        LOAD_REQ,
        LOAD_WAIT,
        LOAD_WR,
        RUN
    } state_t;

    localparam logic [2:0]  ADDR_LO_CYC        = 3'd3;
    localparam logic [2:0]  WR_REQ_CYC         = 3'd6;
    localparam logic [2:0]  RD_END_CYC         = 3'd0;
    localparam logic [23:0] FLASH_BASE_DEFAULT = 24'h050000;

endpackage

// File: rtl/cosmem_xclkgen.sv
// CPU clock generator: even divider, 50% duty XCLK, rise/fall ticks and the
// 3-bit bus-cycle counter that TPB resynchronises.
module cosmem_xclkgen #(
    parameter int XCLK_DIV = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       tpb,
    output logic       xclk,
    output logic       rise_tick,
    output logic       fall_tick,
    output logic       tpb_force,
    output logic [2:0] xclk_cycle
);

    localparam int DW = $clog2(XCLK_DIV);
    localparam logic [DW-1:0] HALF    = DW'(XCLK_DIV / 2);
    localparam logic [DW-1:0] HALF_M1 = DW'(XCLK_DIV / 2 - 1);
    localparam logic [DW-1:0] LAST    = DW'(XCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_next;

    // Ticks flag the clk edge on which xclk changes, so events line up with it.
    assign rise_tick = run && (div_cnt == HALF_M1);
    assign fall_tick = run && (div_cnt == LAST);
    assign tpb_force = rise_tick && tpb;

    always_comb begin
        div_next = div_cnt;
        if (!run || div_cnt == LAST) begin
            div_next = '0;
        end else begin
            div_next = div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt    <= '0;
            xclk       <= 1'b0;
            xclk_cycle <= 3'd0;
        end else begin
            div_cnt <= div_next;
            xclk    <= (div_next >= HALF);
            if (tpb_force) begin
                xclk_cycle <= 3'd7;
            end else if (fall_tick) begin
                xclk_cycle <= xclk_cycle + 3'd1;
            end
        end
    end

endmodule

// File: rtl/cosmem_ctl.sv
// COSMAC 1802 memory controller: preloads on-chip RAM from SPI flash, then
// serves CPU read/write bus cycles with a write-protected ROM window.
module cosmem_ctl
    import cosmem_pkg::*;
#(
    parameter int          MEM_WORDS  = 1024,
    parameter int          XCLK_DIV   = 8,
    parameter int          LOAD_WORDS = 1024,
    parameter logic [23:0] FLASH_BASE = FLASH_BASE_DEFAULT,
    parameter int          ROM_WORDS  = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        xclk,
    output logic        nwait,
    output logic        clr,
    input  logic        nmwr,
    input  logic        nmrd,
    input  logic        tpa,
    input  logic        tpb,
    input  logic [7:0]  ma,
    output logic        db_oe,
    output logic [7:0]  db_do,
    input  logic [7:0]  db_di,
    output logic        ce,
    output logic        flash_valid,
    input  logic        flash_ready,
    output logic [23:0] flash_addr,
    input  logic [31:0] flash_rdata,
    output logic        load_done
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [16:0] MEM_LIM  = 17'(MEM_WORDS);
    localparam logic [16:0] LOAD_LIM = 17'(LOAD_WORDS);

    state_t      state, next_state;
    logic [16:0] load_ptr;
    logic [1:0]  byte_idx;
    logic [31:0] flash_word;
    logic        load_we, run;

    logic        xclk_rise, xclk_fall, tpb_force;
    logic [2:0]  xclk_cycle;
    logic        init, tpa_q, latch_q, rreq, wreq;
    logic [7:0]  addr_hi, addr_lo;
    logic [15:0] cpu_addr;
    logic        hi_latch, lo_latch, in_range, rom_hit, cpu_we;

    logic          mem_we;
    logic [AW-1:0] wr_idx;
    logic [7:0]    wr_data;
    logic [7:0]    mem [MEM_WORDS];

    assign nwait = 1'b1;
    assign db_oe = !nmrd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_REQ;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD_REQ:  next_state = LOAD_WAIT;
            LOAD_WAIT: if (flash_ready) next_state = LOAD_WR;
            LOAD_WR: begin
                if (byte_idx == 2'd3) begin
                    next_state = (load_ptr + 17'd4 == LOAD_LIM) ? RUN : LOAD_REQ;
                end
            end
            RUN:       next_state = RUN;
            default:   next_state = LOAD_REQ;
        endcase
    end

    always_comb begin
        flash_valid = 1'b0;
        load_we     = 1'b0;
        run         = 1'b0;
        clr         = 1'b0;
        load_done   = 1'b0;
        case (state)
            LOAD_WAIT: flash_valid = 1'b1;
            LOAD_WR:   load_we = 1'b1;
            RUN: begin
                run       = 1'b1;
                clr       = 1'b1;
                load_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_ptr   <= '0;
            byte_idx   <= '0;
            flash_word <= '0;
            flash_addr <= FLASH_BASE;
        end else begin
            if (state == LOAD_REQ) begin
                flash_addr <= FLASH_BASE + 24'(load_ptr);
            end
            if (state == LOAD_WAIT && flash_ready) begin
                flash_word <= flash_rdata;
            end
            if (load_we) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    load_ptr <= load_ptr + 17'd4;
                end
            end
        end
    end

    cosmem_xclkgen #(
        .XCLK_DIV (XCLK_DIV)
    ) u_xclkgen (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .tpb        (tpb),
        .xclk       (xclk),
        .rise_tick  (xclk_rise),
        .fall_tick  (xclk_fall),
        .tpb_force  (tpb_force),
        .xclk_cycle (xclk_cycle)
    );

    assign cpu_addr = {addr_hi, addr_lo};
    assign in_range = {1'b0, cpu_addr} < MEM_LIM;
    assign hi_latch = tpa_q && !tpa;
    assign lo_latch = xclk_rise && (xclk_cycle == ADDR_LO_CYC) && !init;

    generate
        if (ROM_WORDS > 0) begin : g_rom
            assign rom_hit = {1'b0, cpu_addr} < 17'(ROM_WORDS);
        end else begin : g_no_rom
            assign rom_hit = 1'b0;
        end
    endgenerate

    // A pending write lands on the fall tick after the request was seen.
    assign cpu_we = xclk_fall && wreq && in_range && !rom_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tpa_q   <= 1'b0;
            latch_q <= 1'b0;
            addr_hi <= '0;
            addr_lo <= '0;
            init    <= 1'b1;
            rreq    <= 1'b0;
            wreq    <= 1'b0;
            ce      <= 1'b0;
            db_do   <= '0;
        end else begin
            tpa_q   <= tpa;
            latch_q <= hi_latch || lo_latch;
            if (hi_latch) begin
                addr_hi <= ma;
            end
            if (lo_latch) begin
                addr_lo <= ma;
                if (!nmrd) begin
                    rreq <= 1'b1;
                end
            end else if (xclk_fall && xclk_cycle == RD_END_CYC) begin
                rreq <= 1'b0;
            end
            if (tpb_force) begin
                wreq <= 1'b0;
                init <= 1'b0;
            end else if (xclk_fall) begin
                if (wreq) begin
                    wreq <= 1'b0;
                end else if (!nmwr && xclk_cycle == WR_REQ_CYC && !init) begin
                    wreq <= 1'b1;
                end
            end
            if (latch_q) begin
                ce <= in_range;
            end
            if (rreq) begin
                db_do <= in_range ? mem[cpu_addr[AW-1:0]] : 8'hFF;
            end
        end
    end

    // Loader and CPU never write in the same clk: CPU ticks only exist in RUN.
    assign mem_we  = load_we || cpu_we;
    assign wr_idx  = load_we ? {load_ptr[AW-1:2], byte_idx} : cpu_addr[AW-1:0];
    assign wr_data = load_we ? flash_word[{byte_idx, 3'b000} +: 8] : db_di;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_cosmem_ctl.sv
// Scoreboard bench for cosmem_ctl: flash preload, reset abort, CPU bus cycles,
// ROM protection, out-of-range reads and XCLK period for two dividers.
module tb_cosmem_ctl;

    localparam logic [23:0] BASE = 24'h050000;

    logic        clk = 1'b0;
    logic        reset;
    logic        tpa, tpb, nmrd, nmwr;
    logic [7:0]  ma, db_di;
    logic        xclk, nwait, clr, db_oe, ce, flash_valid, flash_ready, load_done;
    logic [7:0]  db_do;
    logic [23:0] flash_addr;
    logic [31:0] flash_rdata;

    logic        xclk2, nwait2, clr2, db_oe2, ce2, flash_valid2, load_done2;
    logic        flash_ready2 = 1'b0;
    logic [7:0]  db_do2;
    logic [23:0] flash_addr2;
    logic [31:0] flash_rdata2 = 32'h0;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] image [2] = '{32'h44332211, 32'h88776655};
    int          delays [4] = '{5, 0, 3, 2};
    int          req_idx = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       ce;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [23:0] fl_q[$];

    always #5 clk = ~clk;

    cosmem_ctl #(
        .MEM_WORDS (1024), .XCLK_DIV (6), .LOAD_WORDS (8),
        .FLASH_BASE (BASE), .ROM_WORDS (16)
    ) dut (
        .clk (clk), .reset (reset), .xclk (xclk), .nwait (nwait), .clr (clr),
        .nmwr (nmwr), .nmrd (nmrd), .tpa (tpa), .tpb (tpb), .ma (ma),
        .db_oe (db_oe), .db_do (db_do), .db_di (db_di), .ce (ce),
        .flash_valid (flash_valid), .flash_ready (flash_ready),
        .flash_addr (flash_addr), .flash_rdata (flash_rdata), .load_done (load_done)
    );

    cosmem_ctl #(
        .MEM_WORDS (1024), .XCLK_DIV (10), .LOAD_WORDS (8),
        .FLASH_BASE (BASE), .ROM_WORDS (0)
    ) dut2 (
        .clk (clk), .reset (reset), .xclk (xclk2), .nwait (nwait2), .clr (clr2),
        .nmwr (nmwr), .nmrd (nmrd), .tpa (tpa), .tpb (tpb), .ma (ma),
        .db_oe (db_oe2), .db_do (db_do2), .db_di (db_di), .ce (ce2),
        .flash_valid (flash_valid2), .flash_ready (flash_ready2),
        .flash_addr (flash_addr2), .flash_rdata (flash_rdata2), .load_done (load_done2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Flash model for the main DUT: per-request latency from a table, abandons a request if valid drops.
    initial begin
        int   d;
        logic abort;
        logic [23:0] off;
        flash_ready = 1'b0;
        flash_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (flash_valid && !flash_ready) begin
                d = delays[req_idx % 4];
                req_idx++;
                abort = 1'b0;
                for (int i = 0; i < d; i++) begin
                    @(posedge clk); #1;
                    if (!flash_valid) abort = 1'b1;
                end
                if (!abort && flash_valid) begin
                    off = flash_addr - BASE;
                    flash_ready = 1'b1;
                    flash_rdata = image[off[2]];
                    @(posedge clk); #1;
                    flash_ready = 1'b0;
                end
            end
        end
    end

    always begin
        @(posedge clk); #1;
        flash_ready2 = flash_valid2 && !flash_ready2;
    end

    always @(negedge clk) begin
        if (flash_valid && flash_ready) begin
            if (fl_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL flash_unexpected: got addr 0x%0h, want no request", flash_addr);
            end else begin
                checkOutput("flash_addr", {8'h0, flash_addr}, {8'h0, fl_q.pop_front()});
            end
        end
    end

    always @(posedge nmrd) begin
        if (rd_q.size() > 0) begin
            rd_exp_t e;
            e = rd_q.pop_front();
            checkOutput({e.name, " db_do"}, {24'h0, db_do}, {24'h0, e.data});
            checkOutput({e.name, " ce"}, {31'h0, ce}, {31'h0, e.ce});
        end
    end

    initial begin
        #500000;
        n_fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_xfall();
        @(negedge xclk);
    endtask

    task automatic wait_xrise();
        @(posedge xclk);
    endtask

    // One CPU machine cycle, entered just before the fall into cycle 0 and left early in cycle 7.
    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] exp_data, input logic exp_ce, input string name);
        rd_exp_t e;
        if (!wr) begin
            e.name = name;
            e.data = exp_data;
            e.ce   = exp_ce;
            rd_q.push_back(e);
        end
        wait_xfall();
        #1;
        tpa = 1'b1;
        ma  = addr[15:8];
        if (!wr) nmrd = 1'b0;
        repeat (2) @(negedge clk);
        tpa = 1'b0;
        repeat (3) wait_xfall();
        #1;
        ma = addr[7:0];
        if (!wr) begin
            wait_xrise();
            #1;
            checkOutput({name, " db_oe"}, {31'h0, db_oe}, 32'h1);
        end
        repeat (3) wait_xfall();
        if (wr) begin
            #1;
            nmwr  = 1'b0;
            db_di = wdata;
        end
        wait_xfall();
        #1;
        nmwr = 1'b1;
        if (!wr) begin
            nmrd = 1'b1;
            #1;
            checkOutput({name, " db_oe released"}, {31'h0, db_oe}, 32'h0);
        end
    endtask

    function automatic logic xsel(input bit sel);
        return sel ? xclk2 : xclk;
    endfunction

    task automatic measure(input bit sel, output int hi, output int lo);
        int guard = 0;
        hi = 0;
        lo = 0;
        while (xsel(sel) !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        while (xsel(sel) !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        while (xsel(sel) === 1'b1 && guard < 100) begin hi++; @(negedge clk); guard++; end
        while (xsel(sel) === 1'b0 && guard < 100) begin lo++; @(negedge clk); guard++; end
    endtask

    initial begin
        int   hi, lo;
        logic clr_early;
        tpa = 1'b0; tpb = 1'b0; nmrd = 1'b1; nmwr = 1'b1; ma = '0; db_di = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);

        checkOutput("reset xclk", {31'h0, xclk}, 32'h0);
        checkOutput("reset nwait", {31'h0, nwait}, 32'h1);
        checkOutput("reset clr", {31'h0, clr}, 32'h0);
        checkOutput("reset db_do", {24'h0, db_do}, 32'h0);
        checkOutput("reset ce", {31'h0, ce}, 32'h0);
        checkOutput("reset flash_valid", {31'h0, flash_valid}, 32'h0);
        checkOutput("reset flash_addr", {8'h0, flash_addr}, {8'h0, BASE});
        checkOutput("reset load_done", {31'h0, load_done}, 32'h0);
        checkOutput("reset db_oe", {31'h0, db_oe}, 32'h0);
        checkOutput("dut2 reset nwait", {31'h0, nwait2}, 32'h1);
        checkOutput("dut2 reset clr", {31'h0, clr2}, 32'h0);
        checkOutput("dut2 reset db_do", {24'h0, db_do2}, 32'h0);
        checkOutput("dut2 reset ce", {31'h0, ce2}, 32'h0);
        checkOutput("dut2 reset db_oe", {31'h0, db_oe2}, 32'h0);
        checkOutput("dut2 reset flash_addr", {8'h0, flash_addr2}, {8'h0, BASE});

        // Start a load, then abort it with reset while the flash is still busy.
        reset = 1'b0;
        for (int i = 0; i < 20 && !flash_valid; i++) @(negedge clk);
        checkOutput("first flash_valid", {31'h0, flash_valid}, 32'h1);
        checkOutput("first flash_addr", {8'h0, flash_addr}, {8'h0, BASE});
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort flash_valid", {31'h0, flash_valid}, 32'h0);
        checkOutput("abort flash_addr", {8'h0, flash_addr}, {8'h0, BASE});
        repeat (2) @(negedge clk);

        fl_q.push_back(24'h050000);
        fl_q.push_back(24'h050004);
        reset = 1'b0;
        clr_early = 1'b0;
        for (int i = 0; i < 300 && !load_done; i++) begin
            @(negedge clk);
            if (clr && !load_done) clr_early = 1'b1;
        end
        checkOutput("load_done", {31'h0, load_done}, 32'h1);
        checkOutput("clr with load_done", {31'h0, clr}, 32'h1);
        checkOutput("clr before load_done", {31'h0, clr_early}, 32'h0);
        checkOutput("flash queue drained", fl_q.size(), 32'h0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] w;
            w = image[i / 4];
            checkOutput($sformatf("preload ram[%0d]", i), {24'h0, dut.mem[i]},
                        {24'h0, w[(i % 4) * 8 +: 8]});
        end

        measure(1'b0, hi, lo);
        checkOutput("div6 xclk high", hi, 32'd3);
        checkOutput("div6 xclk low", lo, 32'd3);
        checkOutput("dut2 load_done", {31'h0, load_done2}, 32'h1);
        measure(1'b1, hi, lo);
        checkOutput("div10 xclk high", hi, 32'd5);
        checkOutput("div10 xclk low", lo, 32'd5);

        // TPB on a rise tick ends the init window and aligns the cycle counter to 7.
        wait_xfall();
        #1;
        tpb = 1'b1;
        wait_xrise();
        #1;
        tpb = 1'b0;

        applyStimulus(1'b0, 16'h0003, 8'h00, 8'h44, 1'b1, "read 0003");
        applyStimulus(1'b1, 16'h0123, 8'hA5, 8'h00, 1'b0, "write 0123");
        applyStimulus(1'b0, 16'h0123, 8'h00, 8'hA5, 1'b1, "read 0123");
        applyStimulus(1'b1, 16'h0007, 8'h5A, 8'h00, 1'b0, "write rom 0007");
        applyStimulus(1'b0, 16'h0007, 8'h00, 8'h88, 1'b1, "read rom 0007");
        applyStimulus(1'b1, 16'h0010, 8'h5A, 8'h00, 1'b0, "write 0010");
        applyStimulus(1'b0, 16'h0010, 8'h00, 8'h5A, 1'b1, "read 0010");
        applyStimulus(1'b1, 16'h03FF, 8'h3C, 8'h00, 1'b0, "write 03FF");
        applyStimulus(1'b0, 16'h03FF, 8'h00, 8'h3C, 1'b1, "read 03FF");
        applyStimulus(1'b0, 16'h0400, 8'h00, 8'hFF, 1'b0, "read 0400");
        applyStimulus(1'b0, 16'h8000, 8'h00, 8'hFF, 1'b0, "read 8000");

        repeat (2) @(negedge clk);
        checkOutput("read queue drained", rd_q.size(), 32'h0);
        checkOutput("load_done held", {31'h0, load_done}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
